uart_tx_scheduler: RTL

Shares one UART transmitter among N_REQ byte sources using round-robin arbitration. It latches the winner's byte and drives the transmitter's data, byte_ready and t_byte inputs. The transmitter has no busy or done output, so this block times each frame itself and reports completion to the requester. It sits directly in front of the UART transmitter in the top-level serial output path.

---
 rtl/uart_pkg.sv | 6 +
 rtl/rr_select.sv | 24 ++
 rtl/uart_tx_scheduler.sv | 68 ++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART scheduler types and constants
package uart_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} sched_state_t;
  localparam int UART_DATA_W = 8;
  localparam int UART_FRAME_BITS = 10;
endpackage

// File: rtl/rr_select.sv
// rr_select: round-robin winner search starting just above the last grant
module rr_select #(
  parameter int N_REQ = 4,
  parameter int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic             gnt_valid,
  output logic [IW-1:0]    gnt_idx
);
  int idx;
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx = '0;
    idx = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % N_REQ;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter with self-timed frames
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int FRAME_BITS = UART_FRAME_BITS,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [N_REQ-1:0]             req,
  input  logic [UART_DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]             ack,
  output logic [N_REQ-1:0]             done,
  output logic [UART_DATA_W-1:0]       tx_data,
  output logic                         byte_ready,
  output logic                         t_byte,
  output logic                         busy
);
  localparam int FC = FRAME_BITS * CLKS_PER_BIT + GUARD_CYCLES;
  localparam int CW = $clog2(FC + 1);
  localparam int IW = $clog2(N_REQ);
  sched_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] last, gnt_idx;
  logic gnt_valid, grant, frame_end;
  rr_select #(.N_REQ(N_REQ)) u_rr (
    .req(req),
    .last(last),
    .gnt_valid(gnt_valid),
    .gnt_idx(gnt_idx)
  );
  always_comb begin
    grant = state == IDLE && en && gnt_valid;
    frame_end = state == WAIT && cnt == CW'(FC - 1);
    nxt = state == IDLE ? (grant ? LOAD : IDLE) :
          state == LOAD ? START :
          state == START ? WAIT :
          frame_end ? IDLE : WAIT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      last <= IW'(N_REQ - 1);
      tx_data <= '0;
      ack <= '0;
      done <= '0;
      byte_ready <= 1'b0;
      t_byte <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (grant) begin
        tx_data <= req_data[UART_DATA_W*gnt_idx +: UART_DATA_W];
        last <= gnt_idx;
      end
      ack <= grant ? N_REQ'(1) << gnt_idx : '0;
      done <= frame_end ? N_REQ'(1) << last : '0;
      byte_ready <= grant;
      t_byte <= state == LOAD;
      busy <= nxt != IDLE;
    end
  end
endmodule
